// File: rtl/debounce_pkg.sv
// debounce_pkg: shared types and constants for the push-button conditioner.
// Repeat-state encoding, counter width helper and 50 MHz default timings.
package debounce_pkg;

   typedef enum logic [1:0] {
      IDLE,
      DELAY,
      RPT
   } rpt_state_t;

   localparam int unsigned DEF_CHANNELS      = 4;
   localparam int unsigned DEF_COUNT_MAX     = 1_500_000;
   localparam int unsigned DEF_REPEAT_DELAY  = 25_000_000;
   localparam int unsigned DEF_REPEAT_PERIOD = 5_000_000;

   // Bits needed to hold 0..max_val, never less than one.
   function automatic int unsigned cnt_width(input int unsigned max_val);
      if (max_val < 1)
         return 1;
      return $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/debounce_channel.sv
// debounce_channel: one button path - synchroniser, stability counter,
// edge pulses and optional auto-repeat sequencer.
module debounce_channel
   import debounce_pkg::*;
#(
   parameter int unsigned COUNT_MAX     = DEF_COUNT_MAX,
   parameter bit          ACTIVE_LOW    = 1'b1,
   parameter bit          REPEAT_EN     = 1'b0,
   parameter int unsigned REPEAT_DELAY  = DEF_REPEAT_DELAY,
   parameter int unsigned REPEAT_PERIOD = DEF_REPEAT_PERIOD
) (
   input  logic clock,
   input  logic resetN,
   input  logic signalIn,
   output logic signalDebounced,
   output logic pressed,
   output logic released,
   output logic autoRepeat
);

   localparam int unsigned SW = cnt_width(COUNT_MAX);
   localparam logic [SW-1:0] STAB_LAST = SW'(COUNT_MAX - 1);
   localparam logic IDLE_RAW = ACTIVE_LOW;

   logic          sync1;
   logic          sync2;
   logic          level;
   logic          differ;
   logic          accept;
   logic          rise;
   logic          fall;
   logic [SW-1:0] stab_cnt;

   // Two-flop synchroniser; resets to the released raw level.
   always_ff @(posedge clock or negedge resetN) begin
      if (!resetN) begin
         sync1 <= IDLE_RAW;
         sync2 <= IDLE_RAW;
      end else begin
         sync1 <= signalIn;
         sync2 <= sync1;
      end
   end

   assign level  = sync2 ^ ACTIVE_LOW;
   assign differ = level != signalDebounced;
   assign accept = differ && (stab_cnt == STAB_LAST);
   assign rise   = accept && level;
   assign fall   = accept && !level;

   // Count consecutive disagreeing cycles; accept the new level at the limit.
   always_ff @(posedge clock or negedge resetN) begin
      if (!resetN) begin
         stab_cnt        <= '0;
         signalDebounced <= 1'b0;
         pressed         <= 1'b0;
         released        <= 1'b0;
      end else begin
         pressed  <= rise;
         released <= fall;
         if (!differ || accept)
            stab_cnt <= '0;
         else
            stab_cnt <= stab_cnt + 1'b1;
         if (accept)
            signalDebounced <= level;
      end
   end

   if (REPEAT_EN) begin : g_rpt

      localparam int unsigned RMAX =
         (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
      localparam int unsigned RW = cnt_width(RMAX);
      localparam logic [RW-1:0] DELAY_LAST  = RW'(REPEAT_DELAY - 1);
      localparam logic [RW-1:0] PERIOD_LAST = RW'(REPEAT_PERIOD - 1);

      rpt_state_t    state;
      rpt_state_t    state_nx;
      logic [RW-1:0] rcnt;
      logic [RW-1:0] rcnt_nx;
      logic          rpt_nx;
      logic          at_last;

      assign at_last = (state == DELAY) ? (rcnt == DELAY_LAST)
                                        : (rcnt == PERIOD_LAST);

      // Repeat sequencer state, interval counter and registered pulse.
      always_ff @(posedge clock or negedge resetN) begin
         if (!resetN) begin
            state      <= IDLE;
            rcnt       <= '0;
            autoRepeat <= 1'b0;
         end else begin
            state      <= state_nx;
            rcnt       <= rcnt_nx;
            autoRepeat <= rpt_nx;
         end
      end

      // Debounced release wins over everything and parks the sequencer.
      always_comb begin
         state_nx = state;
         if (fall) begin
            state_nx = IDLE;
         end else begin
            unique case (state)
               IDLE:    if (rise) state_nx = DELAY;
               DELAY:   if (at_last) state_nx = RPT;
               RPT:     state_nx = RPT;
               default: state_nx = IDLE;
            endcase
         end
      end

      // Interval counting and repeat pulse generation while held.
      always_comb begin
         rcnt_nx = '0;
         rpt_nx  = 1'b0;
         if (!fall) begin
            unique case (state)
               DELAY, RPT: begin
                  if (at_last) begin
                     rpt_nx = 1'b1;
                  end else begin
                     rcnt_nx = rcnt + 1'b1;
                  end
               end
               default: begin
                  rcnt_nx = '0;
                  rpt_nx  = 1'b0;
               end
            endcase
         end
      end

   end else begin : g_no_rpt

      assign autoRepeat = 1'b0;

   end

endmodule

// File: rtl/debounce_bank.sv
// debounce_bank: array of independent button conditioners.
// activated merges the press pulse with auto-repeat pulses per channel.
module debounce_bank
   import debounce_pkg::*;
#(
   parameter int unsigned CHANNELS      = DEF_CHANNELS,
   parameter int unsigned COUNT_MAX     = DEF_COUNT_MAX,
   parameter bit          ACTIVE_LOW    = 1'b1,
   parameter bit          REPEAT_EN     = 1'b0,
   parameter int unsigned REPEAT_DELAY  = DEF_REPEAT_DELAY,
   parameter int unsigned REPEAT_PERIOD = DEF_REPEAT_PERIOD
) (
   input  logic                clock,
   input  logic                resetN,
   input  logic [CHANNELS-1:0] signalIn,
   output logic [CHANNELS-1:0] signalDebounced,
   output logic [CHANNELS-1:0] pressed,
   output logic [CHANNELS-1:0] released,
   output logic [CHANNELS-1:0] autoRepeat,
   output logic [CHANNELS-1:0] activated
);

   for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
      debounce_channel #(
         .COUNT_MAX     (COUNT_MAX),
         .ACTIVE_LOW    (ACTIVE_LOW),
         .REPEAT_EN     (REPEAT_EN),
         .REPEAT_DELAY  (REPEAT_DELAY),
         .REPEAT_PERIOD (REPEAT_PERIOD)
      ) u_ch (
         .clock           (clock),
         .resetN          (resetN),
         .signalIn        (signalIn[i]),
         .signalDebounced (signalDebounced[i]),
         .pressed         (pressed[i]),
         .released        (released[i]),
         .autoRepeat      (autoRepeat[i])
      );
   end

   assign activated = pressed | autoRepeat;

endmodule

// File: tb/tb_debounce_bank.sv
// tb_debounce_bank: directed and random checks of the button conditioner
// against a window-based reference model, with and without auto-repeat.
module tb_debounce_bank;

   localparam int CH = 2;
   localparam int CM = 4;
   localparam int RD = 10;
   localparam int RP = 3;
   localparam int HMAX = 4096;

   logic          clock = 1'b0;
   logic          resetN = 1'b0;
   logic [CH-1:0] signalIn = '1;

   logic [CH-1:0] deb, pr, rl, rp, ac;
   logic [CH-1:0] nr_deb, nr_pr, nr_rl, nr_rp, nr_ac;
   logic [CH-1:0] o_deb, o_pr, o_rl, o_rp, o_ac;
   logic [CH-1:0] n_deb, n_pr, n_rl, n_rp, n_ac;

   int tests = 0;
   int fails = 0;
   int cyc = 0;
   int last_rst = -1;
   bit rst_prev = 1'b0;

   bit hist [CH][HMAX];
   bit m_deb [CH];
   bit m_held [CH];
   int m_p [CH];

   debounce_bank #(
      .CHANNELS(CH), .COUNT_MAX(CM), .ACTIVE_LOW(1'b1), .REPEAT_EN(1'b1),
      .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
   ) dut (
      .clock(clock), .resetN(resetN), .signalIn(signalIn),
      .signalDebounced(deb), .pressed(pr), .released(rl),
      .autoRepeat(rp), .activated(ac)
   );

   debounce_bank #(
      .CHANNELS(CH), .COUNT_MAX(CM), .ACTIVE_LOW(1'b1), .REPEAT_EN(1'b0),
      .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
   ) dut_nr (
      .clock(clock), .resetN(resetN), .signalIn(signalIn),
      .signalDebounced(nr_deb), .pressed(nr_pr), .released(nr_rl),
      .autoRepeat(nr_rp), .activated(nr_ac)
   );

   always #5 clock = ~clock;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s cyc=%0d: got %0h expected %0h", tag, cyc, obs, exp);
      end
   endtask

   // Logical (pressed=1) synchronised-input history; reset erases the past.
   function automatic bit lvl(input int ch, input int idx);
      if (idx < 0 || idx <= last_rst)
         return 1'b0;
      return hist[ch][idx];
   endfunction

   // One cycle: check outputs of cycle cyc, then drive inputs for it.
   task automatic step(input logic [CH-1:0] raw, input logic rstn);
      logic [CH-1:0] e_deb, e_pr, e_rl, e_rp;
      bit flip;
      int d;
      @(posedge clock);
      #1;
      o_deb = deb; o_pr = pr; o_rl = rl; o_rp = rp; o_ac = ac;
      n_deb = nr_deb; n_pr = nr_pr; n_rl = nr_rl;
      n_rp = nr_rp; n_ac = nr_ac;
      e_deb = '0; e_pr = '0; e_rl = '0; e_rp = '0;
      for (int ch = 0; ch < CH; ch++) begin
         if (!rst_prev) begin
            m_deb[ch] = 1'b0;
            m_held[ch] = 1'b0;
         end else begin
            flip = 1'b1;
            for (int k = 1; k <= CM; k++)
               if (lvl(ch, cyc - 2 - k) == m_deb[ch])
                  flip = 1'b0;
            e_pr[ch] = flip && !m_deb[ch];
            e_rl[ch] = flip && m_deb[ch];
            if (flip)
               m_deb[ch] = !m_deb[ch];
            if (e_pr[ch]) begin
               m_held[ch] = 1'b1;
               m_p[ch] = cyc;
            end
            if (e_rl[ch])
               m_held[ch] = 1'b0;
            d = cyc - m_p[ch];
            e_rp[ch] = m_held[ch] && d >= RD && ((d - RD) % RP) == 0;
         end
         e_deb[ch] = m_deb[ch];
      end
      chk("deb", 32'(o_deb), 32'(e_deb));
      chk("pressed", 32'(o_pr), 32'(e_pr));
      chk("released", 32'(o_rl), 32'(e_rl));
      chk("repeat", 32'(o_rp), 32'(e_rp));
      chk("activated", 32'(o_ac), 32'(e_pr | e_rp));
      chk("nr_deb", 32'(n_deb), 32'(e_deb));
      chk("nr_pressed", 32'(n_pr), 32'(e_pr));
      chk("nr_released", 32'(n_rl), 32'(e_rl));
      chk("nr_repeat", 32'(n_rp), 32'(0));
      chk("nr_activated", 32'(n_ac), 32'(e_pr));
      signalIn = raw;
      resetN = rstn;
      for (int ch = 0; ch < CH; ch++)
         hist[ch][cyc] = (raw[ch] == 1'b0);
      if (!rstn)
         last_rst = cyc;
      rst_prev = rstn;
      if (!rstn) begin
         #1;
         chk("async_rst",
             32'({deb, pr, rl, rp, ac, nr_deb, nr_pr, nr_rl, nr_rp, nr_ac}),
             32'(0));
      end
      cyc++;
   endtask

   task automatic settle(input int n);
      for (int i = 0; i < n; i++)
         step(2'b11, 1'b1);
   endtask

   logic [CH-1:0] rnd_raw;
   int run_left [CH];
   int rst_left;

   initial begin
      for (int i = 0; i < 3; i++)
         step(2'b11, 1'b0);
      settle(10);

      // Clean press on channel 0, channel 1 idle.
      for (int t = 0; t < 20; t++) begin
         step(2'b10, 1'b1);
         if (t == 5) chk("A_deb_early", 32'(o_deb[0]), 32'(0));
         if (t == 6) chk("A_pressed", 32'(o_pr[0]), 32'(1));
         if (t == 6) chk("A_activated", 32'(o_ac[0]), 32'(1));
         if (t == 7) chk("A_pulse_width", 32'(o_pr[0]), 32'(0));
         if (t == 7) chk("A_deb_held", 32'(o_deb[0]), 32'(1));
         chk("A_ch1_quiet",
             32'({o_deb[1], o_pr[1], o_rl[1], o_rp[1], o_ac[1]}), 32'(0));
      end
      settle(12);

      // Bounce shorter than the stability window.
      for (int t = 0; t < 20; t++) begin
         step((t < 3 || (t >= 5 && t < 8)) ? 2'b10 : 2'b11, 1'b1);
         chk("B_no_change", 32'({o_deb[0], o_pr[0], o_rl[0]}), 32'(0));
      end

      // Low pulse of exactly the window length.
      for (int t = 0; t < 16; t++) begin
         step((t < 4) ? 2'b10 : 2'b11, 1'b1);
         if (t == 6) chk("B4_pressed", 32'(o_pr[0]), 32'(1));
         if (t == 9) chk("B4_deb", 32'(o_deb[0]), 32'(1));
         if (t == 10) chk("B4_released", 32'(o_rl[0]), 32'(1));
         if (t == 10) chk("B4_deb_off", 32'(o_deb[0]), 32'(0));
      end
      settle(4);

      // Auto-repeat while held, none after release.
      for (int t = 0; t < 46; t++) begin
         step((t < 30) ? 2'b10 : 2'b11, 1'b1);
         chk("C_repeat", 32'(o_rp[0]),
             32'(t >= 16 && t < 36 && ((t - 16) % 3) == 0));
         if (t == 36) chk("C_released", 32'(o_rl[0]), 32'(1));
         chk("C_nr_repeat", 32'(n_rp[0]), 32'(0));
      end
      settle(4);

      // Reset in the middle of a press; still held at release.
      for (int t = 0; t < 24; t++) begin
         step(2'b10, !(t >= 4 && t < 10));
         if (t >= 5 && t <= 10)
            chk("D_held_zero", 32'({o_deb, o_pr}), 32'(0));
         if (t == 15) chk("D_not_yet", 32'(o_pr[0]), 32'(0));
         if (t == 16) chk("D_pressed", 32'(o_pr[0]), 32'(1));
      end
      settle(12);

      // Both channels together, channel 1 lets go early.
      for (int t = 0; t < 21; t++) begin
         step({(t >= 8), 1'b0}, 1'b1);
         if (t == 6) chk("E_pressed", 32'(o_pr), 32'(2'b11));
         if (t == 14) chk("E_released", 32'(o_rl), 32'(2'b10));
         if (t == 16) chk("E_repeat", 32'(o_rp), 32'(2'b01));
      end
      settle(12);

      // Random run-length stimulus with occasional resets.
      rnd_raw = 2'b11;
      run_left[0] = 0;
      run_left[1] = 0;
      rst_left = 0;
      for (int t = 0; t < 1200; t++) begin
         for (int ch = 0; ch < CH; ch++) begin
            if (run_left[ch] == 0) begin
               rnd_raw[ch] = 1'($urandom_range(0, 1));
               run_left[ch] = $urandom_range(1, 25);
            end
            run_left[ch]--;
         end
         if (rst_left == 0 && $urandom_range(0, 299) == 0)
            rst_left = $urandom_range(1, 3);
         step(rnd_raw, rst_left == 0);
         if (rst_left > 0)
            rst_left--;
      end
      settle(12);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
